// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and opcode helpers for seq_alu.
package alu_pkg;

    localparam logic [3:0] ADD_OP = 4'b0000;
    localparam logic [3:0] SUB_OP = 4'b0001;
    localparam logic [3:0] AND_OP = 4'b0010;
    localparam logic [3:0] OR_OP  = 4'b0011;
    localparam logic [3:0] XOR_OP = 4'b0100;
    localparam logic [3:0] NOT_OP = 4'b0101;
    localparam logic [3:0] SLA_OP = 4'b0110;
    localparam logic [3:0] SRA_OP = 4'b0111;
    localparam logic [3:0] SRL_OP = 4'b1000;
    localparam logic [3:0] MUL_OP = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == SLA_OP) || (op == SRA_OP) || (op == SRL_OP);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational evaluation of the single-cycle ops (ADD..NOT) and their flags.
// Any other opcode yields res = 0, carry = 0 (reserved-opcode behaviour).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        // Two's complement subtract: carry out set means no borrow (A >= B).
        diff    = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
        res_o   = '0;
        carry_o = 1'b0;
        case (op_i)
            ADD_OP: {carry_o, res_o} = sum;
            SUB_OP: {carry_o, res_o} = diff;
            AND_OP: res_o = a_i & b_i;
            OR_OP:  res_o = a_i | b_i;
            XOR_OP: res_o = a_i ^ b_i;
            NOT_OP: res_o = ~a_i;
            default: begin
                res_o   = '0;
                carry_o = 1'b0;
            end
        endcase
        zero_o = (res_o == '0);
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops via alu_core,
// bit-serial shifts and radix-2 shift-add multiply in the EXEC state.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       aluOp,
    input  logic [SHW-1:0]   shiftAmount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zeroFlag,
    output logic             carryFlag
);

    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

    state_e               state_q;
    logic [3:0]           op_q;
    logic [SHW:0]         cnt_q;
    logic [WIDTH-1:0]     work_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     res_q;
    logic                 zero_q;
    logic                 carry_q;

    logic [WIDTH-1:0]     shift_d;
    logic                 shift_out;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_d;

    logic [WIDTH-1:0]     core_res;
    logic                 core_zero;
    logic                 core_carry;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (operandA),
        .b_i     (operandB),
        .op_i    (aluOp),
        .res_o   (core_res),
        .zero_o  (core_zero),
        .carry_o (core_carry)
    );

    // One shift step and one multiply step per EXEC cycle.
    always_comb begin
        shift_d   = {1'b0, work_q[WIDTH-1:1]};
        shift_out = work_q[0];
        case (op_q)
            SLA_OP: begin
                shift_d   = {work_q[WIDTH-2:0], 1'b0};
                shift_out = work_q[WIDTH-1];
            end
            SRA_OP: shift_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: ;
        endcase
        // Multiplier sits in the low half of acc_q; multiplicand stays in work_q.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, work_q} : '0);
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    op_q   <= aluOp;
                    work_q <= operandA;
                    acc_q  <= {{WIDTH{1'b0}}, operandB};
                    if (aluOp == MUL_OP) begin
                        cnt_q   <= CNT_FULL;
                        state_q <= ST_EXEC;
                    end else if (is_shift(aluOp) && shiftAmount != '0) begin
                        cnt_q   <= {1'b0, shiftAmount};
                        state_q <= ST_EXEC;
                    end else if (is_shift(aluOp)) begin
                        res_q   <= operandA;
                        zero_q  <= (operandA == '0);
                        carry_q <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        res_q   <= core_res;
                        zero_q  <= core_zero;
                        carry_q <= core_carry;
                        state_q <= ST_DONE;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    acc_q <= acc_d;
                    if (op_q != MUL_OP) work_q <= shift_d;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_DONE;
                        if (op_q == MUL_OP) begin
                            res_q   <= acc_d[WIDTH-1:0];
                            zero_q  <= (acc_d[WIDTH-1:0] == '0);
                            carry_q <= |acc_d[2*WIDTH-1:WIDTH];
                        end else begin
                            res_q   <= shift_d;
                            zero_q  <= (shift_d == '0);
                            carry_q <= shift_out;
                        end
                    end
                end
                ST_DONE: if (out_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign zeroFlag  = zero_q;
    assign carryFlag = carry_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle ALU with a valid/ready handshake on both input and result. It executes the team's op set (ADD, SUB, AND, OR, XOR, NOT, SLA, SRA, SRL) at WIDTH bits, adds variable shift distances and an unsigned multiply, and registers every result with zero and carry flags. It sits between the decode/issue stage and writeback. It is the sequential successor to the single-cycle 32-bit combinational ALU.

## Interface
- WIDTH, 32: datapath width; a power of two, minimum 4.
- SHW, $clog2(WIDTH): local, derived width of shiftAmount.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- operandA  in  WIDTH  first operand; the only operand used by NOT and the shifts.
- operandB  in  WIDTH  second operand.
- aluOp  in  4  opcode.
- shiftAmount  in  SHW  shift distance, 0..WIDTH-1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- res  out  WIDTH  result.
- zeroFlag  out  1  res == 0.
- carryFlag  out  1  carry, borrow-free or shifted-out bit, per op.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A, 0110 SLA, 0111 SRA, 1000 SRL, 1001 MUL (unsigned; res is the low WIDTH bits). Opcodes 1010-1111 are reserved.
- FSM states: IDLE, EXEC, DONE.
  - IDLE to DONE: on accept of a single-cycle op, or a shift with shiftAmount = 0.
  - IDLE to EXEC: on accept of a shift with shiftAmount > 0, or MUL.
  - EXEC to DONE: when the iteration counter expires.
  - DONE to IDLE: on out_valid && out_ready.
- Accept means in_valid && in_ready at a rising edge. The block captures operands, aluOp and shiftAmount at accept, so inputs may change afterwards.
- ADD: {carry, res} = A + B.
- SUB: {carry, res} = A + ~B + 1. carry = 1 if and only if A >= B unsigned.
- AND, OR, XOR, NOT: carry = 0.
- SLA: shifts left with zero fill, 1 bit per EXEC cycle. carry = the last bit shifted out of the MSB.
- SRA: shifts right with sign fill, 1 bit per EXEC cycle. carry = the last bit shifted out of the LSB.
- SRL: shifts right with zero fill, 1 bit per EXEC cycle. carry = the last bit shifted out of the LSB.
- Shift with shiftAmount = 0: res = A, carry = 0.
- MUL: radix-2 shift-add over WIDTH EXEC cycles into a 2*WIDTH accumulator. res = low half. carry = 1 if and only if the high half is nonzero.
- Reserved opcodes: res = 0, zeroFlag = 1, carryFlag = 0, with single-cycle latency.
- zeroFlag is computed from the final res for every op.
- In DONE, res and both flags hold stable until the result is taken. in_valid is ignored outside IDLE.

## Timing
- Reset: rst_n low forces, immediately and asynchronously, state = IDLE, out_valid = 0, res = 0, zeroFlag = 0, carryFlag = 0. in_ready is 1 as long as the state is IDLE, including during reset.
- Reset mid-EXEC or mid-DONE aborts the operation. The in-flight result is discarded and never presented.
- Latency is measured from the accept edge to the first cycle with out_valid = 1:
  - single-cycle ops, reserved opcodes and shiftAmount = 0: 1 cycle;
  - shift by k > 0: k + 1 cycles;
  - MUL: WIDTH + 1 cycles.
- in_ready drops in the cycle after accept.
- After the result is taken, in_ready returns in the next cycle. There is no accept in the same cycle as the take, so peak throughput is one operation every 2 cycles.
- out_valid never deasserts without out_ready being high.

## Structure
- Package alu_pkg holds:
  - the opcode localparams (ADD_OP through MUL_OP);
  - the state encoding for IDLE/EXEC/DONE.
- Sub-module alu_core: combinational evaluation of the single-cycle ops and their flags, parametrised by WIDTH.
- seq_alu holds:
  - the FSM;
  - the iteration counter (SHW+1 bits);
  - the shift/MUL working registers;
  - the output registers.

## Test plan
All scenarios use WIDTH = 32.
- ADD 30 + 10: res = 40, zeroFlag = 0, carryFlag = 0, out_valid 1 cycle after accept. ADD 0xFFFFFFFF + 1: res = 0, zeroFlag = 1, carryFlag = 1.
- SUB 30 - 10: res = 20, carryFlag = 1. SUB 10 - 30: res = 0xFFFFFFEC, carryFlag = 0.
- Shifts:
  - SRA 0xFFFFFFFE by 1: res = 0xFFFFFFFF, carryFlag = 0, latency 2.
  - SRL 14 by 3: res = 1, carryFlag = 1, latency 4.
  - SLA 7 by 0: res = 7, carryFlag = 0, latency 1.
- MUL 14 × 3: res = 42, carryFlag = 0. MUL 0x10000 × 0x10000: res = 0, zeroFlag = 1, carryFlag = 1. Both with out_valid exactly 33 cycles after accept.
- Backpressure: hold out_ready low for 5 cycles after out_valid rises. Required: res and flags unchanged, in_ready = 0, a pulsed in_valid ignored. Raise out_ready: in_ready = 1 on the next cycle.
- Assert rst_n low 10 cycles into a MUL: out_valid = 0 and in_ready = 1 immediately. A following ADD 1 + 2 returns res = 3. Reserved opcode 1111: res = 0, zeroFlag = 1.
